// File: rtl/sram_confreg_resp.sv
// sram_confreg_resp: responder for the CPU's single-cycle SRAM-style data port.
// Serves a word-addressed data RAM and a small config-register window
// (timer, LEDs, synchronized switches, number display, scratch).
//
// Ports:
//   clk, resetn            single clock, asynchronous active-low reset
//   sram_we                full-word write strobe (every cycle is an access)
//   sram_addr[31:0]        byte address, bits [1:0] ignored
//   sram_wdata[31:0]       write data
//   sram_rdata[31:0]       registered read data, one cycle after the address
//   switch[7:0]            asynchronous board switches
//   led[15:0]              LED register
//   num_data[31:0]         number-display register
module sram_confreg_resp #(
  parameter int          ADDR_W  = 12,
  parameter logic [15:0] CONF_HI = 16'hbfaf
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [31:0] num_data
);

  localparam int DEPTH = 1 << ADDR_W;

  // Word offsets (sram_addr[15:2]) inside the config window.
  localparam logic [13:0] OFF_TIMER   = 14'h0;
  localparam logic [13:0] OFF_LED     = 14'h1;
  localparam logic [13:0] OFF_SWITCH  = 14'h2;
  localparam logic [13:0] OFF_NUM     = 14'h3;
  localparam logic [13:0] OFF_SCRATCH = 14'h4;

  logic              conf_sel;
  logic [13:0]       conf_off;
  logic [ADDR_W-1:0] ram_idx;
  logic              conf_we;
  logic              ram_we;

  logic [31:0] ram [DEPTH];
  logic [31:0] timer;
  logic [31:0] scratch;
  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;
  logic [31:0] conf_rd;

  // Byte-lane bits carry no meaning on a full-word port.
  logic unused_addr_lo;
  assign unused_addr_lo = ^sram_addr[1:0];

  assign conf_sel = (sram_addr[31:16] == CONF_HI);
  assign conf_off = sram_addr[15:2];
  // Upper address bits are dropped, so the RAM aliases every DEPTH words.
  assign ram_idx  = sram_addr[ADDR_W+1:2];
  assign conf_we  = sram_we & conf_sel;
  // RAM has no reset of its own; gating with resetn drops writes on
  // edges that land while reset is held.
  assign ram_we   = sram_we & ~conf_sel & resetn;

  // Config read mux; unmapped offsets read as zero.
  always_comb begin
    conf_rd = '0;
    case (conf_off)
      OFF_TIMER:   conf_rd = timer;
      OFF_LED:     conf_rd = {16'b0, led};
      OFF_SWITCH:  conf_rd = {24'b0, sw_sync};
      OFF_NUM:     conf_rd = num_data;
      OFF_SCRATCH: conf_rd = scratch;
      default:     conf_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= sram_wdata;
  end

  // Read-first: the value sampled here is the pre-edge contents, so a
  // read-during-write (RAM or config) returns the old value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sram_rdata <= '0;
    else         sram_rdata <= conf_sel ? conf_rd : ram[ram_idx];
  end

  // Timer: a load replaces the increment for that cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          timer <= '0;
    else if (conf_we && conf_off == OFF_TIMER) timer <= sram_wdata;
    else                                  timer <= timer + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led      <= '0;
      num_data <= '0;
      scratch  <= '0;
    end else if (conf_we) begin
      case (conf_off)
        OFF_LED:     led      <= sram_wdata[15:0];
        OFF_NUM:     num_data <= sram_wdata;
        OFF_SCRATCH: scratch  <= sram_wdata;
        default:     ;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
    end
  end

endmodule

// File: tb/tb_sram_confreg_resp.sv
// Scoreboard bench for sram_confreg_resp: the driver pushes the expected
// response of each access into a queue; a monitor pops and compares one
// cycle later.
module tb_sram_confreg_resp;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [7:0]  switch;
  logic [15:0] led;
  logic [31:0] num_data;

  always #5 clk = ~clk;

  sram_confreg_resp #(.ADDR_W(12), .CONF_HI(16'hbfaf)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .switch     (switch),
    .led        (led),
    .num_data   (num_data)
  );

  typedef struct {
    bit          chk;
    logic [31:0] rdata;
    logic [15:0] led;
    logic [31:0] num;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain variables and a sparse word memory.
  logic [31:0] mem [int];
  logic [31:0] m_timer, m_num, m_scratch;
  logic [15:0] m_led;
  logic [7:0]  m_switch;
  bit          m_sw_valid;

  function automatic void model_reset();
    m_timer = 0; m_num = 0; m_scratch = 0; m_led = 0; m_sw_valid = 0;
  endfunction

  function automatic bit is_conf(input logic [31:0] a);
    return (a >> 16) == 32'hbfaf;
  endfunction

  function automatic void model_read(input logic [31:0] a, output bit known,
                                     output logic [31:0] v);
    int off, idx;
    known = 1; v = 0;
    if (is_conf(a)) begin
      off = int'((a & 32'hffff) >> 2);
      if (off == 0) v = m_timer;
      else if (off == 1) v = {16'b0, m_led};
      else if (off == 2) begin v = {24'b0, m_switch}; known = m_sw_valid; end
      else if (off == 3) v = m_num;
      else if (off == 4) v = m_scratch;
    end else begin
      idx = int'((a >> 2) % 4096);
      if (mem.exists(idx)) v = mem[idx];
      else known = 0;
    end
  endfunction

  function automatic void model_step(input bit we, input logic [31:0] a,
                                     input logic [31:0] wd);
    int off;
    bit loaded = 0;
    if (we && is_conf(a)) begin
      off = int'((a & 32'hffff) >> 2);
      if (off == 0) begin m_timer = wd; loaded = 1; end
      else if (off == 1) m_led = wd[15:0];
      else if (off == 3) m_num = wd;
      else if (off == 4) m_scratch = wd;
    end else if (we) begin
      mem[int'((a >> 2) % 4096)] = wd;
    end
    if (!loaded) m_timer = m_timer + 1;
  endfunction

  task automatic access(input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input string nm);
    exp_t e;
    bit known;
    logic [31:0] v;
    @(negedge clk);
    sram_we = we; sram_addr = a; sram_wdata = wd;
    model_read(a, known, v);
    model_step(we, a, wd);
    e.chk = known; e.rdata = v; e.led = m_led; e.num = m_num; e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: one expected entry per access, compared after its edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.chk) check({mon_e.name, ".rdata"}, sram_rdata, mon_e.rdata);
      check({mon_e.name, ".led"}, {16'b0, led}, {16'b0, mon_e.led});
      check({mon_e.name, ".num"}, num_data, mon_e.num);
    end
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  int offs[8] = '{32'h0, 32'h4, 32'h8, 32'hc, 32'h10, 32'h14, 32'h20, 32'h1004};
  logic [31:0] his[4] = '{32'h0000, 32'h1c00, 32'h8000, 32'hbfae};

  initial begin
    bit found;
    logic [31:0] a, wd;
    bit we;
    resetn = 0; sram_we = 0; sram_addr = 0; sram_wdata = 0; switch = 8'h00;
    model_reset();

    // Reset hold with toggling inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sram_we = $urandom_range(0, 1);
      sram_addr = 32'hbfaf0000 | (i * 4);
      sram_wdata = $urandom;
    end
    @(posedge clk); #1;
    check("rst.rdata", sram_rdata, 0);
    check("rst.led", {16'b0, led}, 0);
    check("rst.num", num_data, 0);
    #1; resetn = 1; sram_we = 0;

    // Directed sequence.
    access(0, 32'hbfaf0000, 0, "timer_first");
    access(0, 32'h1c000100, 0, "filler");
    access(0, 32'hbfaf0000, 0, "timer_second");
    access(1, 32'h1c000100, 32'hdeadbeef, "ram_wr");
    access(0, 32'h1c000100, 0, "ram_rd");
    access(1, 32'h1c000100, 32'h12345678, "ram_rdw");
    access(0, 32'h1c000100, 0, "ram_rd2");
    access(1, 32'h00000004, 32'ha5a5a5a5, "alias_wr");
    access(0, 32'h00004004, 0, "alias_rd");
    access(1, 32'hbfaf0004, 32'hffff1234, "led_wr");
    access(0, 32'hbfaf0004, 0, "led_rd");
    access(1, 32'hbfaf000c, 32'h00000007, "num_wr");
    access(1, 32'hbfaf0020, 32'h00000001, "unmapped_wr");
    access(0, 32'hbfaf0020, 0, "unmapped_rd");
    access(1, 32'hbfaf0000, 32'hfffffffe, "timer_load");
    access(0, 32'hbfaf0000, 0, "timer_fe");
    access(0, 32'hbfaf0000, 0, "timer_ff");
    access(0, 32'hbfaf0000, 0, "timer_wrap");

    // Switch synchronizer: value must show up within three reads.
    #1; switch = 8'h5a;
    found = 0;
    for (int i = 0; i < 3 && !found; i++) begin
      access(0, 32'hbfaf0008, 0, "sw_wait");
      #1;
      if (sram_rdata == 32'h0000005a) found = 1;
    end
    check("switch_sync", {31'b0, found}, 1);
    m_switch = 8'h5a; m_sw_valid = 1;
    access(0, 32'hbfaf0008, 0, "sw_rd");

    // Asynchronous reset between edges; RAM write during reset dropped.
    access(0, 32'h1c000100, 0, "pre_rst_rd");
    #3; resetn = 0; #1;
    check("async.rdata", sram_rdata, 0);
    check("async.led", {16'b0, led}, 0);
    check("async.num", num_data, 0);
    @(negedge clk);
    sram_we = 1; sram_addr = 32'h1c000100; sram_wdata = 32'h0badf00d;
    @(posedge clk); #2;
    resetn = 1; sram_we = 0;
    model_reset();
    access(0, 32'h1c000100, 0, "rst_wr_blocked");
    access(0, 32'hbfaf0000, 0, "timer_after_rst");
    access(0, 32'h00004004, 0, "alias_after_rst");
    m_sw_valid = 1;

    // Randomized traffic mixing RAM and config targets.
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 2) == 0);
      wd = $urandom;
      if ($urandom_range(0, 9) < 5) begin
        a = (his[$urandom_range(0, 3)] << 16) | ($urandom_range(0, 3) << 14)
          | (($urandom_range(0, 15) + ($urandom_range(0, 1) ? 32'h800 : 0)) << 2)
          | $urandom_range(0, 3);
      end else begin
        a = 32'hbfaf0000 | offs[$urandom_range(0, 7)] | $urandom_range(0, 3);
      end
      access(we, a, wd, "rand");
    end

    @(posedge clk); #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_confreg_resp.md
# sram_confreg_resp

Responder side of the single-cycle SRAM-style data port driven by the CPU core (`we`, `addr`, `wdata` out of the core; `rdata` back into it). It serves two targets behind that one port:

- a word-addressed data RAM;
- a small configuration-register window holding a free-running timer, LED outputs, synchronized switch inputs, a number-display register and a scratch register.

It sits between the CPU data port and the board-level I/O. It is also the data-memory model used by simulation benches.

## Interface

Parameters:
- `ADDR_W`, default 12: RAM word-address width (RAM depth = 2^ADDR_W words).
- `CONF_HI`, default 16'hbfaf: value of `sram_addr[31:16]` that selects the config window.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `sram_we` in 1: write strobe, full 32-bit word.
- `sram_addr` in 32: byte address; bits [1:0] ignored.
- `sram_wdata` in 32: write data.
- `sram_rdata` out 32: read data, registered.
- `switch` in 8: asynchronous board switches.
- `led` out 16: LED register.
- `num_data` out 32: number-display register.

## Operation

Target select:
- `conf_sel = (sram_addr[31:16] == CONF_HI)`.
- Otherwise the access goes to RAM at word index `sram_addr[ADDR_W+1:2]`. Higher address bits alias, so the RAM wraps every 2^ADDR_W words.

Config registers, decoded on `sram_addr[15:0]`:
- 0x0000 TIMER: 32-bit counter, +1 every cycle, wraps 0xffffffff→0.
  - A write loads `sram_wdata`, with no increment in that cycle.
- 0x0004 LED: writable; bits [15:0] drive `led`; reads zero-extended.
- 0x0008 SWITCH: read-only `{24'b0, switch_sync}`, where `switch_sync` is a 2-flop synchronizer of `switch`. Writes ignored.
- 0x000c NUM: writable 32-bit; drives `num_data`.
- 0x0010 SCRATCH: writable 32-bit; no side effects.
- Any other offset: reads 0, writes ignored. No error signalled.

Every cycle is an access; there is no valid/handshake:
- Cycle with `sram_we=1`: write the selected target at the edge.
- Cycle with `sram_we=0`: read the selected target.
- `sram_rdata` is loaded at every edge with the selected target's value *before* that edge's update (read-first), including on write cycles.

RAM contents are not reset or initialized. The bench preloads them via hierarchical `$readmemh` if needed.

## Timing

Reset values, while `resetn=0` and immediately after release:
- `sram_rdata` = 0, `led` = 0, `num_data` = 0.
- TIMER = 0, SCRATCH = 0, switch synchronizer flops = 0.

Reset behaviour:
- Reset is asserted asynchronously and takes effect without a clock edge.
- While `resetn=0`, RAM writes are blocked; a write whose edge coincides with `resetn=0` is dropped.
- Assertion mid-operation discards any in-flight read result; `sram_rdata` goes to 0.
- TIMER starts counting at the first edge after release: it reads 1 after that edge.

Read latency:
- Exactly 1 cycle: address presented in cycle N appears on `sram_rdata` after edge N, stable throughout cycle N+1.

Write latency:
- A write in cycle N is visible to a read in cycle N+1.
- That read's data appears in cycle N+2.
- `led` and `num_data` change right after edge N.

Read-during-write:
- Same address in the same cycle returns the old value.
- TIMER read on its write cycle returns the pre-load count.

Switch path:
- A change on `switch` is visible in SWITCH reads 2–3 edges later: 2 synchronizer edges, plus the read register.

Back-to-back operation:
- Accesses can be issued every cycle with no bubbles.
- Alternating targets (RAM, config) causes no hazard.

## Test plan

- **Reset:** hold `resetn=0` 3 cycles, toggling `sram_we`/`sram_addr`.
  - Required: `sram_rdata`, `led`, `num_data` all 0.
  - After release, read 0xbfaf0000 in the first cycle → `sram_rdata`=0x00000000 next cycle.
  - Reread two cycles later → 0x00000002.
- **RAM write/read and read-first:**
  - Write 0x1c000100 ← 0xdeadbeef, then read same address → 0xdeadbeef one cycle later.
  - Same-cycle write 0x12345678 to that address → `sram_rdata`=0xdeadbeef.
  - Next read → 0x12345678.
- **Aliasing** (ADDR_W=12): write 0x00000004 ← 0xa5a5a5a5, read 0x00004004 → 0xa5a5a5a5.
- **LED and NUM:**
  - Write 0xbfaf0004 ← 0xffff1234 → `led`=16'h1234 after the edge.
  - Read 0xbfaf0004 → 0x00001234.
  - Write 0xbfaf000c ← 0x00000007 → `num_data`=7.
  - Write 0xbfaf0020 ← 0x1 → no register changes; readback 0.
- **TIMER:**
  - Write 0xbfaf0000 ← 0xfffffffe, then read on the following cycle → 0xfffffffe.
  - Read on the next cycle → 0xffffffff.
  - Read on the next cycle → 0x00000000 (wrap).
- **Switch sync and async reset:**
  - Set `switch`=8'h5a, continuously read 0xbfaf0008 → 0x0000005a within 3 cycles.
  - Drop `resetn` between edges → outputs 0 before the next edge.
